// File: rtl/seq011_scan_arbiter.sv
// Round-robin shared "011" Mealy detector: accepts one WIDTH-bit word per scan and
// streams it MSB-first. Optional first-match position reporting under SEQ011_FIRSTPOS_EN.
module seq011_scan_arbiter #(
    parameter int  WIDTH = 8,
    parameter int  CNT_W = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic [IDX_W-1:0] first_pos,
    output logic             first_vld
);

    typedef enum logic {IDLE, SCAN} state_t;
    typedef enum logic [1:0] {DA, DB, DC} det_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_nx;
    det_t             det, det_nx;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_id;

    logic             win_vld, win_id, accept, last_bit, bit_in, hit;
    logic             gnt0_d, gnt1_d, done_d, busy_d;

    // Both pending: the requester that did not win last time goes next.
    always_comb begin
        win_vld  = req0 | req1;
        win_id   = (req0 && req1) ? ~last_id : req1;
        accept   = (state == IDLE) && win_vld;
        last_bit = (state == SCAN) && (idx == LAST_IDX);
        bit_in   = sreg[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_vld)  state_nx = SCAN;
            SCAN:    if (last_bit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt0_d = accept && !win_id;
        gnt1_d = accept &&  win_id;
        done_d = last_bit;
        busy_d = (state_nx == SCAN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            gnt0 <= gnt0_d;
            gnt1 <= gnt1_d;
            done <= done_d;
            busy <= busy_d;
        end
    end

    // Mealy detector; after a match it restarts at A so matches never overlap.
    always_comb begin
        det_nx = det;
        hit    = 1'b0;
        case (det)
            DA:      det_nx = bit_in ? DA : DB;
            DB:      det_nx = bit_in ? DC : DB;
            DC: begin
                det_nx = bit_in ? DA : DB;
                hit    = bit_in;
            end
            default: det_nx = DA;
        endcase
        cnt_nx = (hit && cnt != '1) ? cnt + 1'b1 : cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg      <= '0;
            idx       <= '0;
            det       <= DA;
            cnt       <= '0;
            last_id   <= 1'b1;
            done_id   <= 1'b0;
            match_cnt <= '0;
        end else if (accept) begin
            sreg    <= win_id ? data1 : data0;
            idx     <= '0;
            det     <= DA;
            cnt     <= '0;
            last_id <= win_id;
        end else if (state == SCAN) begin
            sreg <= sreg << 1;
            idx  <= idx + 1'b1;
            det  <= det_nx;
            cnt  <= cnt_nx;
            if (last_bit) begin
                match_cnt <= cnt_nx;
                done_id   <= last_id;
            end
        end
    end

`ifdef SEQ011_FIRSTPOS_EN
    logic [IDX_W-1:0] fpos;
    logic             fvld;
    logic [IDX_W-1:0] fpos_nx;
    logic             fvld_nx;

    always_comb begin
        fvld_nx = fvld | hit;
        fpos_nx = (!fvld && hit) ? idx : fpos;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpos      <= '0;
            fvld      <= 1'b0;
            first_pos <= '0;
            first_vld <= 1'b0;
        end else if (accept) begin
            fpos <= '0;
            fvld <= 1'b0;
        end else if (state == SCAN) begin
            fpos <= fpos_nx;
            fvld <= fvld_nx;
            if (last_bit) begin
                first_pos <= fpos_nx;
                first_vld <= fvld_nx;
            end
        end
    end
`else
    assign first_pos = '0;
    assign first_vld = 1'b0;
`endif

endmodule

// File: tb/tb_seq011_scan_arbiter.sv
// Bench for seq011_scan_arbiter: directed scenarios plus random traffic, checked every
// cycle against a word-level model (substring search + cycle countdown).
module tb_seq011_scan_arbiter;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] data0 = '0, data1 = '0;

    logic gnt0, gnt1, busy, done, done_id, first_vld;
    logic [CNT_W-1:0] match_cnt;
    logic [IDX_W-1:0] first_pos;

    logic gnt0_1, gnt1_1, busy_1, done_1, done_id_1, first_vld_1;
    logic [0:0] match_cnt_1;
    logic [IDX_W-1:0] first_pos_1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq011_scan_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .first_pos(first_pos), .first_vld(first_vld)
    );

    seq011_scan_arbiter #(.WIDTH(WIDTH), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_1), .gnt1(gnt1_1), .busy(busy_1), .done(done_1), .done_id(done_id_1),
        .match_cnt(match_cnt_1), .first_pos(first_pos_1), .first_vld(first_vld_1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Greedy left-to-right search for "011"; index 0 is the MSB.
    function automatic void scan_word(input logic [WIDTH-1:0] w, output int n, output int fp);
        int i;
        n = 0; fp = -1; i = 0;
        while (i <= WIDTH - 3) begin
            if (!w[WIDTH-1-i] && w[WIDTH-2-i] && w[WIDTH-3-i]) begin
                if (fp < 0) fp = i + 2;
                n++;
                i += 3;
            end else i++;
        end
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model state
    int m_gnt0 = 0, m_gnt1 = 0, m_busy = 0, m_done = 0, m_id = 0;
    int m_raw = 0, m_fpos = 0, m_fvld = 0, m_last = 1;
    int rem = 0, cur = 0, p_raw = 0, p_fp = 0, p_fv = 0;

    always begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_gnt0 = 0; m_gnt1 = 0; m_busy = 0; m_done = 0; m_id = 0;
            m_raw = 0; m_fpos = 0; m_fvld = 0; m_last = 1; rem = 0;
        end else begin
            m_gnt0 = 0; m_gnt1 = 0; m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1; m_busy = 0; m_id = cur;
                    m_raw = p_raw; m_fpos = p_fp; m_fvld = p_fv;
                end
            end else if (req0 || req1) begin
                int w, fp;
                w = (req0 && req1) ? (m_last == 0 ? 1 : 0) : (req1 ? 1 : 0);
                cur = w; m_last = w;
                scan_word(w != 0 ? data1 : data0, p_raw, fp);
                p_fv = (fp >= 0) ? 1 : 0;
                p_fp = (fp >= 0) ? fp : 0;
                rem = WIDTH; m_busy = 1;
                if (w != 0) m_gnt1 = 1; else m_gnt0 = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt0", gnt0, m_gnt0);
            chk("gnt1", gnt1, m_gnt1);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("done_id", done_id, m_id);
            chk("match_cnt", match_cnt, sat(m_raw, CNT_W));
`ifdef SEQ011_FIRSTPOS_EN
            chk("first_pos", first_pos, m_fpos);
            chk("first_vld", first_vld, m_fvld);
`else
            chk("first_pos", first_pos, 0);
            chk("first_vld", first_vld, 0);
`endif
            chk("c1_done", done_1, m_done);
            chk("c1_done_id", done_id_1, m_id);
            chk("c1_match_cnt", match_cnt_1, sat(m_raw, 1));
            chk("c1_gnt", {gnt1_1, gnt0_1}, m_gnt1 * 2 + m_gnt0);
            chk("c1_busy", busy_1, m_busy);
        end
    end

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic expect_res(input int id, input int cnt, input int fp, input int fv);
        bit ok;
        wait_done(ok);
        if (ok) begin
            chk("lit_done_id", done_id, id);
            chk("lit_match_cnt", match_cnt, cnt);
            chk("lit_match_cnt_sat1", match_cnt_1, cnt > 0 ? 1 : 0);
`ifdef SEQ011_FIRSTPOS_EN
            chk("lit_first_pos", first_pos, fp);
            chk("lit_first_vld", first_vld, fv);
`else
            chk("lit_first_pos", first_pos, 0 * fp);
            chk("lit_first_vld", first_vld, 0 * fv);
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_first", {first_vld, first_pos}, 0);
        reset = 0;
    endtask

    initial begin
        int n;
        bit seen;
        do_reset();

        // 1: single word, latency and result
        @(negedge clk);
        req0 = 1; data0 = 8'b0110_1100;
        @(negedge clk);
        chk("s1_gnt0", gnt0, 1);
        chk("s1_busy", busy, 1);
        req0 = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        chk("s1_latency", n, 8);
        chk("s1_match_cnt", match_cnt, 2);
        chk("s1_done_id", done_id, 0);

        // 2: no matches
        req0 = 1; data0 = 8'b0101_0101;
        @(negedge clk); req0 = 0;
        expect_res(0, 0, 0, 0);

        // 4: last-bit match counted
        req0 = 1; data0 = 8'b0001_1011;
        @(negedge clk); req0 = 0;
        expect_res(0, 2, 4, 1);

        // 3: round robin out of reset with both requesters held
        do_reset();
        req0 = 1; data0 = 8'b0011_0011;
        req1 = 1; data1 = 8'b0110_0110;
        expect_res(0, 2, 3, 1);
        expect_res(1, 2, 2, 1);
        expect_res(0, 2, 3, 1);
        req0 = 0; req1 = 0;

        // 5: reset mid-scan aborts
        repeat (10) @(negedge clk);
        req0 = 1; data0 = 8'b0110_1100;
        @(negedge clk); req0 = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        #1;
        chk("s5_busy", busy, 0);
        chk("s5_match_cnt", match_cnt, 0);
        chk("s5_done_id", done_id, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done) seen = 1; end
        chk("s5_no_done", seen, 0);
        req0 = 1; data0 = 8'b0110_1100;
        @(negedge clk);
        chk("s5_gnt0", gnt0, 1);
        req0 = 0;
        expect_res(0, 2, 2, 1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                @(negedge clk);
                reset = 0;
            end
            if (gnt0) begin
                req0 = 1'($urandom_range(0, 1)); data0 = WIDTH'($urandom);
            end else if (req0) begin
                if ($urandom_range(0, 9) == 0) req0 = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1; data0 = WIDTH'($urandom);
            end
            if (gnt1) begin
                req1 = 1'($urandom_range(0, 1)); data1 = WIDTH'($urandom);
            end else if (req1) begin
                if ($urandom_range(0, 9) == 0) req1 = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1; data1 = WIDTH'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
